// File: rtl/sram_rd_pkg.sv
// Shared definitions for the SRAM burst reader.
//   state_t    : burst FSM encoding (IDLE / RUN / DRAIN)
//   SKID_DEPTH : entries in the output buffer that absorbs the SRAM read latency
package sram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/sram_rd_skid.sv
// 2-entry synchronous FIFO holding {last, data} words returned by the SRAM.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : drop all stored entries (occupancy to 0)
//   push, push_data,
//   push_last            : write one word at the tail
//   pop                  : remove the head word (ignored when empty)
//   head_data, head_last : current head word (meaningful while occ > 0)
//   occ                  : number of stored words, 0..2
module sram_rd_skid
  import sram_rd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last,
  output logic [1:0]       occ
);

  // Depth is exactly two, so one-bit read/write indices toggle between slots.
  logic [WIDTH:0] entry_q [SKID_DEPTH];
  logic           wr_idx;
  logic           rd_idx;
  logic [1:0]     occ_q;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (occ_q != 2'd0);
  // A push into a full buffer is only accepted when the head leaves the same cycle.
  assign do_push = push && ((occ_q < 2'(SKID_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) entry_q[i] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      occ_q  <= 2'd0;
    end else if (flush) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (do_push) begin
        entry_q[wr_idx] <= {push_last, push_data};
        wr_idx          <= ~wr_idx;
      end
      if (do_pop) rd_idx <= ~rd_idx;
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data = entry_q[rd_idx][WIDTH-1:0];
  assign head_last = entry_q[rd_idx][WIDTH];
  assign occ       = occ_q;

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read initiator for a single-port synchronous SRAM (1-cycle registered read).
// Accepts {start address, word count}, issues sequential reads (address wraps at
// the top of the array) and streams the words out with last-word marking.
// Optional feature macro: SRAM_RD_ABORT_EN adds an 'abort' input that cancels an
// active burst, flushing buffered and in-flight words.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_addr,
//   cmd_len                          : burst command (len 0 = no-op, saturates at depth)
//   mem_addr, mem_write_en,
//   mem_data_out                     : SRAM port (write enable held at 0)
//   dout_valid/dout_ready, dout_data,
//   dout_last                        : output word stream
//   busy                             : FSM not idle
//   abort                            : (SRAM_RD_ABORT_EN only) cancel active burst
//   dbg_state, dbg_occ               : FSM state and output-buffer occupancy
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// a producer holding valid keeps its payload stable until that edge, and valid never
// depends on ready.
module sram_burst_reader
  import sram_rd_pkg::*;
#(
  parameter int ADDR  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [ADDR:0]    cmd_len,
  output logic [ADDR-1:0]  mem_addr,
  output logic             mem_write_en,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout_data,
  output logic             dout_last,
  output logic             busy,
`ifdef SRAM_RD_ABORT_EN
  input  logic             abort,
`endif
  output state_t           dbg_state,
  output logic [1:0]       dbg_occ
);

  localparam logic [ADDR:0] DEPTH_W = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] ONE_W   = {{ADDR{1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [ADDR-1:0] rd_ptr;
  logic [ADDR:0]   remaining;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      occ;
  logic [2:0]      fill;
  logic [ADDR:0]   len_sat;
  logic            cmd_fire;
  logic            pop;
  logic            issue;
  logic            issue_last;
  logic            abort_act;

`ifdef SRAM_RD_ABORT_EN
  assign abort_act = abort && (state != ST_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign len_sat   = (cmd_len > DEPTH_W) ? DEPTH_W : cmd_len;
  assign pop       = dout_valid && dout_ready;

  // Words buffered plus the word still coming back from the SRAM. Issuing keeps
  // this at most 2; a same-cycle pop frees a slot for the new read.
  assign fill       = {1'b0, occ} + {2'b00, inflight};
  assign issue      = (state == ST_RUN) && !abort_act &&
                      ((fill < 3'(SKID_DEPTH)) || pop);
  assign issue_last = issue && (remaining == ONE_W);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire && (len_sat != '0)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort_act)       state_nxt = ST_IDLE;
        else if (issue_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave once nothing is in flight and the buffer empties after this pop.
        if (abort_act) state_nxt = ST_IDLE;
        else if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop)))
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rd_ptr        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        rd_ptr    <= cmd_addr;
        remaining <= len_sat;
      end else if (issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      inflight      <= issue;
      inflight_last <= issue_last;
    end
  end

  sram_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_act),
    .push      (inflight && !abort_act),
    .push_data (mem_data_out),
    .push_last (inflight_last),
    .pop       (pop),
    .head_data (dout_data),
    .head_last (dout_last),
    .occ       (occ)
  );

  assign dout_valid   = (occ != 2'd0);
  assign mem_addr     = rd_ptr;
  assign mem_write_en = 1'b0;
  assign busy         = (state != ST_IDLE);
  assign dbg_state    = state;
  assign dbg_occ      = occ;

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;
  import sram_rd_pkg::*;

  localparam int ADDR  = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [ADDR-1:0]  cmd_addr;
  logic [ADDR:0]    cmd_len;
  logic [ADDR-1:0]  mem_addr;
  logic             mem_write_en;
  logic [WIDTH-1:0] mem_data_out = '0;
  logic             dout_valid;
  logic             dout_ready;
  logic [WIDTH-1:0] dout_data;
  logic             dout_last;
  logic             busy;
  state_t           dbg_state;
  logic [1:0]       dbg_occ;
`ifdef SRAM_RD_ABORT_EN
  logic             abort;
`endif

  sram_burst_reader #(.ADDR(ADDR), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_data    (dout_data),
    .dout_last    (dout_last),
    .busy         (busy),
`ifdef SRAM_RD_ABORT_EN
    .abort        (abort),
`endif
    .dbg_state    (dbg_state),
    .dbg_occ      (dbg_occ)
  );

  // ---------------- clock / reset / SRAM model ----------------
  always #5 clk = ~clk;

  logic [WIDTH-1:0] sram_mem [16];
  always @(posedge clk) mem_data_out <= sram_mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / check ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];
  logic           stall_q = 1'b0;
  logic [WIDTH:0] stall_word;

  always @(negedge clk) begin
    logic [WIDTH:0] w;
    check("occ_le_2", (dbg_occ <= 2'd2), 1);
    if (stall_q && dout_valid && rst_n)
      check("stall_hold", {dout_last, dout_data}, stall_word);
    if (dout_valid && dout_ready) begin
      check("sb_word_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("sb_word", {dout_last, dout_data}, w);
      end
      n_pop++;
    end
    stall_q    = dout_valid && !dout_ready && rst_n;
    stall_word = {dout_last, dout_data};
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem(input logic [WIDTH-1:0] base);
    for (int i = 0; i < 16; i++) sram_mem[i] = base + WIDTH'(i);
  endtask

  // Expected words for a burst over memory loaded with load_mem(base).
  task automatic expect_burst(input logic [WIDTH-1:0] base, input int a, input int l);
    int n;
    n = (l > 16) ? 16 : l;
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), base + WIDTH'((a + i) % 16)});
  endtask

  // Called just after a rising edge; the command is taken on the next edge.
  task automatic send_cmd(input logic [ADDR-1:0] a, input logic [ADDR:0] l);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input bit toggle, output int cyc);
    cyc = 0;
    while (busy && cyc < max_cyc) begin
      if (toggle) dout_ready = ~dout_ready;
      tick();
      cyc++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int cyc;
    int pops0;
    int wrap_addr [4];
    wrap_addr[0] = 14; wrap_addr[1] = 15; wrap_addr[2] = 0; wrap_addr[3] = 1;

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    dout_ready = 1'b1;
`ifdef SRAM_RD_ABORT_EN
    abort      = 1'b0;
`endif
    load_mem(32'h0);
    tick();
    tick();

    // Reset values
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_data", dout_data, 0);
    check("rst_dout_last", dout_last, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_write_en", mem_write_en, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // Test 1: mem[0]=1, mem[1]=2, addr 0 len 2, exact cycle timing
    sram_mem[0] = 32'h1;
    sram_mem[1] = 32'h2;
    exp_q.push_back({1'b0, 32'h1});
    exp_q.push_back({1'b1, 32'h2});
    send_cmd(4'd0, 5'd2);
    @(negedge clk);
    check("t1_busy_c1", busy, 1);
    check("t1_valid_c1", dout_valid, 0);
    check("t1_addr_c1", mem_addr, 0);
    @(negedge clk);
    check("t1_valid_c2", dout_valid, 0);
    check("t1_state_c2", dbg_state, ST_RUN);
    check("t1_addr_c2", mem_addr, 1);
    @(negedge clk);
    check("t1_valid_c3", dout_valid, 1);
    check("t1_data_c3", dout_data, 32'h1);
    check("t1_last_c3", dout_last, 0);
    @(negedge clk);
    check("t1_valid_c4", dout_valid, 1);
    check("t1_data_c4", dout_data, 32'h2);
    check("t1_last_c4", dout_last, 1);
    check("t1_busy_c4", busy, 1);
    check("t1_state_c4", dbg_state, ST_DRAIN);
    @(negedge clk);
    check("t1_busy_c5", busy, 0);
    check("t1_valid_c5", dout_valid, 0);
    check("t1_drained", exp_q.size(), 0);
    tick();

    // Test 2: address wrap 14,15,0,1
    load_mem(32'h100);
    expect_burst(32'h100, 14, 4);
    send_cmd(4'd14, 5'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_mem_addr", mem_addr, wrap_addr[i]);
    end
    tick();
    wait_idle(20, 1'b0, cyc);
    check("wrap_drained", exp_q.size(), 0);

    // Test 3: backpressure, 16 words with ready toggling
    load_mem(32'hCAFE_0000);
    expect_burst(32'hCAFE_0000, 0, 16);
    pops0 = n_pop;
    send_cmd(4'd0, 5'd16);
    wait_idle(100, 1'b1, cyc);
    dout_ready = 1'b1;
    check("bp_drained", exp_q.size(), 0);
    check("bp_word_count", n_pop - pops0, 16);
    tick();

    // Test 4: len 0 is a no-op
    pops0 = n_pop;
    send_cmd(4'd5, 5'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("len0_busy", busy, 0);
      check("len0_valid", dout_valid, 0);
    end
    check("len0_no_words", n_pop - pops0, 0);
    tick();

    // Test 5: len 31 saturates to 16 words, full-throughput busy = 18 cycles
    load_mem(32'h300);
    expect_burst(32'h300, 5, 31);
    pops0 = n_pop;
    send_cmd(4'd5, 5'd31);
    wait_idle(40, 1'b0, cyc);
    check("sat_word_count", n_pop - pops0, 16);
    check("sat_busy_cycles", cyc, 18);
    check("sat_drained", exp_q.size(), 0);
    tick();

    // Test 6: asynchronous reset in the middle of an 8-word burst
    load_mem(32'h400);
    expect_burst(32'h400, 0, 8);
    send_cmd(4'd0, 5'd8);
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_data", dout_data, 0);
    check("mid_rst_last", dout_last, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_write_en", mem_write_en, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back({1'b1, 32'h403});
    pops0 = n_pop;
    send_cmd(4'd3, 5'd1);
    wait_idle(20, 1'b0, cyc);
    check("post_rst_word_count", n_pop - pops0, 1);
    check("post_rst_drained", exp_q.size(), 0);
    tick();

`ifdef SRAM_RD_ABORT_EN
    // Test 7: abort after 3 of 10 words
    load_mem(32'h500);
    expect_burst(32'h500, 0, 10);
    pops0 = n_pop;
    send_cmd(4'd0, 5'd10);
    cyc = 0;
    while ((n_pop - pops0) < 3 && cyc < 30) begin
      tick();
      cyc++;
    end
    check("abort_three_words", n_pop - pops0, 3);
    abort      = 1'b1;
    dout_ready = 1'b0;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("abort_valid", dout_valid, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_stays_quiet", dout_valid, 0);
    end
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
